// File: rtl/timer_dev_pkg.sv
// Shared definitions for the timer peripheral: register offsets, mode codes,
// CTRL bit positions and FSM state encoding.
package timer_dev_pkg;

    // Register offsets as seen on Addr (PrAddr[3:2])
    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;

    // CTRL.Mode codes; 1x is reserved and behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    // CTRL bit indices
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev_if.sv
// Device-bus port of the timer: register select, write strobe/data,
// combinational read data and the level interrupt line.
interface timer_dev_if #(
    parameter int DW = 32
);
    logic [1:0]    Addr;
    logic          We;
    logic [DW-1:0] DIn;
    logic [DW-1:0] DOut;
    logic          IRQ;

    modport master (output Addr, We, DIn, input DOut, IRQ);
    modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_dev.sv
// Programmable down-counter with one-shot and auto-reload modes.
// Register file (CTRL/PRESET/COUNT) + 4-state FSM + decrementer.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int DW     = 32,
    parameter int CTRL_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    timer_dev_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DW-1:0]     preset_q;
    logic [DW-1:0]     count_q;
    logic              irq_flag_q;

    logic en, auto_mode, ctrl_wr, preset_wr;

    assign en        = ctrl_q[CTRL_EN];
    assign auto_mode = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
    assign ctrl_wr   = bus.We && (bus.Addr == TIMER_CTRL);
    assign preset_wr = bus.We && (bus.Addr == TIMER_PRESET);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: CNT checks En before the zero test so a pause freezes COUNT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_LOAD;
            S_LOAD: state_d = S_CNT;
            S_CNT: begin
                if (!en)
                    state_d = S_IDLE;
                else if ((count_q == '0) || (count_q == DW'(1)))
                    state_d = S_INT;
            end
            S_INT:  state_d = auto_mode ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // CTRL: CPU write wins over the hardware En clear at the end of a one-shot
    always_ff @(posedge clk) begin
        if (rst)
            ctrl_q <= '0;
        else if (ctrl_wr)
            ctrl_q <= bus.DIn[CTRL_W-1:0];
        else if (state_q == S_INT && !auto_mode)
            ctrl_q[CTRL_EN] <= 1'b0;
    end

    // PRESET: only sampled at LOAD, so writes mid-count affect the next period
    always_ff @(posedge clk) begin
        if (rst)            preset_q <= '0;
        else if (preset_wr) preset_q <= bus.DIn;
    end

    // COUNT: load on LOAD, decrement in CNT while enabled, never wraps below 0
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case (state_q)
                S_LOAD: count_q <= preset_q;
                S_CNT:  if (en && count_q != '0) count_q <= count_q - DW'(1);
                default: ;
            endcase
        end
    end

    // irq_flag: register writes clear it and beat a same-edge set. In
    // auto-reload INT is always followed by LOAD, so clearing there makes
    // the flag a one-cycle pulse; a held one-shot flag can only reach LOAD
    // through a CTRL write, which has already cleared it.
    always_ff @(posedge clk) begin
        if (rst)
            irq_flag_q <= 1'b0;
        else if (ctrl_wr || preset_wr)
            irq_flag_q <= 1'b0;
        else if (state_q == S_INT)
            irq_flag_q <= 1'b1;
        else if (state_q == S_LOAD)
            irq_flag_q <= 1'b0;
    end

    // Read mux, combinational on Addr, no side effects
    always_comb begin
        bus.DOut = '0;
        case (bus.Addr)
            TIMER_CTRL:   bus.DOut = {{(DW-CTRL_W){1'b0}}, ctrl_q};
            TIMER_PRESET: bus.DOut = preset_q;
            TIMER_COUNT:  bus.DOut = count_q;
            default:      bus.DOut = '0;
        endcase
    end

    assign bus.IRQ = irq_flag_q & ctrl_q[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev. Expected COUNT/IRQ/CTRL values come from
// a timeline model: cycles elapsed since the enabling CTRL write, the PRESET
// value and the mode determine everything through plain arithmetic.
module tb_timer_dev;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    timer_dev_if #(.DW(32)) bus ();

    timer_dev #(.DW(32), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle; inputs settle before the edge, return 1ns after it
    task automatic step(input bit we, input logic [1:0] a, input logic [31:0] d);
        bus.We   = we;
        bus.Addr = a;
        bus.DIn  = d;
        @(posedge clk);
        #1;
        bus.We = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.Addr = a;
        #1;
        d = bus.DOut;
    endtask

    // Timeline model. e = edges since the enabling CTRL write (valid for e>=2).
    // From e=2 each period is: LOAD edge (COUNT=N), C counting edges, one INT
    // edge that raises the flag, where C = max(N,1). One-shot stops after
    // the first INT with the flag held and En cleared.
    function automatic void model(input int n, input bit auto_m, input int e,
                                  output logic [31:0] cnt, output bit flg, output bit en);
        int c, p, s, pos;
        c = (n == 0) ? 1 : n;
        p = c + 2;
        s = e - 2;
        if (!auto_m && s >= c + 1) begin
            cnt = 0; flg = 1'b1; en = 1'b0;
        end else begin
            pos = s % p;
            if (pos == 0)      cnt = n;
            else if (pos <= c) cnt = (n > pos) ? n - pos : 0;
            else               cnt = 0;
            flg = (pos == c + 1);
            en  = 1'b1;
        end
    endfunction

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        step(1'b1, 2'd1, $urandom);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            n_tests++;
            if (d !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_dout addr=%0d got=%h exp=0", a, d);
            end
        end
        n_tests++;
        if (bus.IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got=%b exp=0", bus.IRQ);
        end
        // state IDLE: with En=0 nothing loads over a few cycles
        repeat (3) step(1'b0, 2'd0, 0);
        rd(2'd2, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle_count got=%h exp=0", d);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d, ecnt;
        bit flg, en;
        int n, c, m;
        logic [1:0] mode;
        bit im;
        logic [3:0] ctrl;
        for (int it = 0; it < 4; it++) begin
            n    = (it == 0) ? 5 : $urandom_range(0, 9);
            m    = $urandom_range(0, 2);
            mode = (it == 0) ? 2'b00 : ((m == 0) ? 2'b00 : 2'(m + 1));
            im   = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ctrl = {im, mode, 1'b1};
            c    = (n == 0) ? 1 : n;
            step(1'b1, 2'd1, n);
            step(1'b1, 2'd0, {28'd0, ctrl});
            for (int e = 1; e <= c + 6; e++) begin
                step(1'b0, 2'd0, 0);
                if (e >= 2) begin
                    model(n, 1'b0, e, ecnt, flg, en);
                    rd(2'd2, d);
                    n_tests++;
                    if (d !== ecnt) begin
                        n_fail++;
                        $display("FAIL oneshot_count n=%0d e=%0d got=%0d exp=%0d", n, e, d, ecnt);
                    end
                    n_tests++;
                    if (bus.IRQ !== (flg & im)) begin
                        n_fail++;
                        $display("FAIL oneshot_irq n=%0d e=%0d got=%b exp=%b", n, e, bus.IRQ, flg & im);
                    end
                end
            end
            rd(2'd0, d);
            n_tests++;
            if (d !== {28'd0, im, mode, 1'b0}) begin
                n_fail++;
                $display("FAIL oneshot_ctrl_en_cleared got=%h exp=%h", d, {28'd0, im, mode, 1'b0});
            end
            step(1'b1, 2'd0, 0);
            n_tests++;
            if (bus.IRQ !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot_irq_clear got=%b exp=0", bus.IRQ);
            end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d, ecnt;
        bit flg, en;
        int n;
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 3 : $urandom_range(1, 6);
            step(1'b1, 2'd1, n);
            step(1'b1, 2'd0, 32'hB);
            for (int e = 1; e <= 2 + 3 * (n + 2) + 1; e++) begin
                step(1'b0, 2'd0, 0);
                if (e >= 2) begin
                    model(n, 1'b1, e, ecnt, flg, en);
                    rd(2'd2, d);
                    n_tests++;
                    if (d !== ecnt) begin
                        n_fail++;
                        $display("FAIL auto_count n=%0d e=%0d got=%0d exp=%0d", n, e, d, ecnt);
                    end
                    n_tests++;
                    if (bus.IRQ !== flg) begin
                        n_fail++;
                        $display("FAIL auto_irq n=%0d e=%0d got=%b exp=%b", n, e, bus.IRQ, flg);
                    end
                end
            end
            rd(2'd0, d);
            n_tests++;
            if (d !== 32'hB) begin
                n_fail++;
                $display("FAIL auto_ctrl_en_kept got=%h exp=b", d);
            end
            step(1'b1, 2'd0, 0);
            repeat (4) step(1'b0, 2'd0, 0);
        end
    endtask

    task automatic test_mask_pause();
        logic [31:0] d, ecnt;
        bit flg, en;
        // masked: flag sets internally, IRQ stays low, En still clears
        step(1'b1, 2'd1, 2);
        step(1'b1, 2'd0, 32'h1);
        for (int e = 1; e <= 8; e++) begin
            step(1'b0, 2'd0, 0);
            n_tests++;
            if (bus.IRQ !== 1'b0) begin
                n_fail++;
                $display("FAIL mask_irq e=%0d got=%b exp=0", e, bus.IRQ);
            end
        end
        rd(2'd0, d);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL mask_ctrl got=%h exp=0", d);
        end
        // pause: disable mid-count at edge 5, COUNT freezes at N-3
        step(1'b1, 2'd1, 10);
        step(1'b1, 2'd0, 32'h1);
        for (int e = 1; e <= 4; e++) begin
            step(1'b0, 2'd0, 0);
            if (e >= 2) begin
                model(10, 1'b0, e, ecnt, flg, en);
                rd(2'd2, d);
                n_tests++;
                if (d !== ecnt) begin
                    n_fail++;
                    $display("FAIL pause_pre_count e=%0d got=%0d exp=%0d", e, d, ecnt);
                end
            end
        end
        step(1'b1, 2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 2'd0, 0);
            rd(2'd2, d);
            n_tests++;
            if (d !== 32'd7) begin
                n_fail++;
                $display("FAIL pause_frozen k=%0d got=%0d exp=7", k, d);
            end
        end
        // resume: reload from PRESET, then count down again
        step(1'b1, 2'd0, 32'h1);
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 2'd0, 0);
            if (e >= 2) model(10, 1'b0, e, ecnt, flg, en);
            else        ecnt = 32'd7;
            rd(2'd2, d);
            n_tests++;
            if (d !== ecnt) begin
                n_fail++;
                $display("FAIL resume_count e=%0d got=%0d exp=%0d", e, d, ecnt);
            end
        end
        step(1'b1, 2'd0, 32'h0);
        repeat (4) step(1'b0, 2'd0, 0);
    endtask

    task automatic test_edges();
        logic [31:0] d, ecnt;
        bit flg, en;
        // PRESET=0: IRQ rises after t0+4
        step(1'b1, 2'd1, 0);
        step(1'b1, 2'd0, 32'h9);
        for (int e = 1; e <= 6; e++) begin
            step(1'b0, 2'd0, 0);
            n_tests++;
            if (bus.IRQ !== (e >= 4)) begin
                n_fail++;
                $display("FAIL zero_preset_irq e=%0d got=%b exp=%b", e, bus.IRQ, (e >= 4));
            end
        end
        // COUNT is read-only; Addr3 reads zero
        step(1'b1, 2'd2, 32'h55);
        step(1'b1, 2'd3, 32'hAA);
        rd(2'd2, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL count_write_ignored got=%h exp=0", d);
        end
        rd(2'd3, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL addr3_read got=%h exp=0", d);
        end
        step(1'b1, 2'd0, 32'h0);
        // PRESET rewritten mid-count does not disturb the running COUNT
        step(1'b1, 2'd1, 8);
        step(1'b1, 2'd0, 32'h1);
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) step(1'b1, 2'd1, 3);
            else        step(1'b0, 2'd0, 0);
            if (e >= 2) begin
                model(8, 1'b0, e, ecnt, flg, en);
                rd(2'd2, d);
                n_tests++;
                if (d !== ecnt) begin
                    n_fail++;
                    $display("FAIL preset_midcount e=%0d got=%0d exp=%0d", e, d, ecnt);
                end
            end
        end
        rd(2'd1, d);
        n_tests++;
        if (d !== 32'd3) begin
            n_fail++;
            $display("FAIL preset_readback got=%0d exp=3", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        // one-shot: CTRL write on the INT edge wins, flag stays clear
        step(1'b1, 2'd1, 2);
        step(1'b1, 2'd0, 32'h9);
        repeat (4) step(1'b0, 2'd0, 0);
        step(1'b1, 2'd0, 32'hC);
        rd(2'd0, d);
        n_tests++;
        if (d !== 32'hC) begin
            n_fail++;
            $display("FAIL collide_ctrl got=%h exp=c", d);
        end
        n_tests++;
        if (bus.IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_irq got=%b exp=0", bus.IRQ);
        end
        step(1'b0, 2'd0, 0);
        n_tests++;
        if (bus.IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_irq_after got=%b exp=0", bus.IRQ);
        end
        // auto-reload: PRESET write on the INT edge suppresses that pulse only
        step(1'b1, 2'd1, 2);
        step(1'b1, 2'd0, 32'hB);
        for (int e = 1; e <= 9; e++) begin
            if (e == 5) step(1'b1, 2'd1, 2);
            else        step(1'b0, 2'd0, 0);
            if (e == 5 || e == 9) begin
                n_tests++;
                if (bus.IRQ !== (e == 9)) begin
                    n_fail++;
                    $display("FAIL collide_auto_irq e=%0d got=%b exp=%b", e, bus.IRQ, (e == 9));
                end
            end
        end
        step(1'b1, 2'd0, 32'h0);
        repeat (4) step(1'b0, 2'd0, 0);
        // reset mid-count beats a simultaneous write
        step(1'b1, 2'd1, 20);
        step(1'b1, 2'd0, 32'h9);
        repeat (5) step(1'b0, 2'd0, 0);
        rst = 1'b1;
        step(1'b1, 2'd1, 7);
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            n_tests++;
            if (d !== 32'd0) begin
                n_fail++;
                $display("FAIL midrst_dout addr=%0d got=%h exp=0", a, d);
            end
        end
        n_tests++;
        if (bus.IRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_irq got=%b exp=0", bus.IRQ);
        end
        repeat (3) step(1'b0, 2'd0, 0);
        rd(2'd2, d);
        n_tests++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_idle_count got=%h exp=0", d);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.Addr = 2'd0;
        bus.We   = 1'b0;
        bus.DIn  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask_pause();
        test_edges();
        test_collision();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
